// File: rtl/npc_pkg.sv
// Shared constants for the program-counter unit: next-PC select codes and default vectors.
package npc_pkg;

  localparam logic [2:0] NPC_SEQ  = 3'b000;
  localparam logic [2:0] NPC_J    = 3'b001;
  localparam logic [2:0] NPC_BRPC = 3'b010;
  localparam logic [2:0] NPC_BR4  = 3'b011;
  localparam logic [2:0] NPC_JR   = 3'b100;
  localparam logic [2:0] NPC_JAL  = 3'b101;
  localparam logic [2:0] NPC_RET  = 3'b110;
  localparam logic [2:0] NPC_RSV  = 3'b111;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;

endpackage

// File: rtl/npc_pc_unit_if.sv
// Bundle between the IF-stage controller (master) and the PC unit (slave).
interface npc_pc_unit_if #(
  parameter int WIDTH = 32
) ();

  // No valid/ready pair: the PC advances on every edge unless stall is high;
  // exc_req overrides stall, and npc/pc_add_4 are combinational views of the current pc.
  logic             stall;
  logic             exc_req;
  logic [2:0]       npc_op;
  logic [15:0]      imm_16;
  logic [25:0]      imm_26;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_add_4;
  logic [WIDTH-1:0] npc;
  logic             ras_empty;

  modport master (
    output stall, exc_req, npc_op, imm_16, imm_26, rs_val,
    input  pc, pc_add_4, npc, ras_empty
  );

  modport slave (
    input  stall, exc_req, npc_op, imm_16, imm_26, rs_val,
    output pc, pc_add_4, npc, ras_empty
  );

endinterface

// File: rtl/npc_ras.sv
// Return-address stack: circular buffer with saturating count, used when NPC_RAS_EN is defined.
// A push when full overwrites the oldest entry; a pop when empty is ignored.
module npc_ras #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_top,
  output logic             o_empty
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    w_top_idx;
  logic             w_full;

  // r_wptr is the next free slot; power-of-two depth makes the wrap free.
  assign w_top_idx = r_wptr - 1'b1;
  assign o_top     = r_mem[w_top_idx];
  assign o_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(RAS_DEPTH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_count <= '0;
    end else if (i_push) begin
      r_wptr <= r_wptr + 1'b1;
      if (!w_full) r_count <= r_count + 1'b1;
    end else if (i_pop && !o_empty) begin
      r_wptr  <= w_top_idx;
      r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && i_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/npc_pc_unit.sv
// Registered PC with next-PC mux, stall hold and exception redirect.
// Optional return-address stack for jr $31 prediction when NPC_RAS_EN is defined.
module npc_pc_unit
  import npc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(DEF_RESET_PC),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(DEF_EXC_VEC),
  parameter int               RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  npc_pc_unit_if.slave  bus
);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_add_4;
  logic [WIDTH-1:0] w_off;
  logic [WIDTH-1:0] w_j_tgt;
  logic [WIDTH-1:0] w_npc;

  if (WIDTH < 28 || RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_param_chk
    $error("npc_pc_unit: WIDTH must be >= 28 and RAS_DEPTH a power of two >= 2");
  end

  assign w_pc_add_4 = r_pc + WIDTH'(4);
  assign w_off      = {{(WIDTH-18){bus.imm_16[15]}}, bus.imm_16, 2'b00};

  // Jumps keep the PC bits above the 28-bit region reachable by imm_26.
  if (WIDTH > 28) begin : g_j_hi
    assign w_j_tgt = {r_pc[WIDTH-1:28], bus.imm_26, 2'b00};
  end else begin : g_j_lo
    assign w_j_tgt = {bus.imm_26, 2'b00};
  end

  logic w_adv;
  assign w_adv = rst_n && !bus.exc_req && !bus.stall;

`ifdef NPC_RAS_EN
  logic [WIDTH-1:0] w_ras_top;
  logic             w_ras_empty;
  logic             w_push;
  logic             w_pop;

  assign w_push = w_adv && (bus.npc_op == NPC_JAL);
  assign w_pop  = w_adv && (bus.npc_op == NPC_RET);

  npc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_pc_add_4),
    .o_top   (w_ras_top),
    .o_empty (w_ras_empty)
  );

  assign bus.ras_empty = w_ras_empty;
`else
  assign bus.ras_empty = 1'b1;
`endif

  always_comb begin
    w_npc = w_pc_add_4;
    case (bus.npc_op)
      NPC_SEQ:  w_npc = w_pc_add_4;
      NPC_J:    w_npc = w_j_tgt;
      NPC_BRPC: w_npc = r_pc + w_off;
      NPC_BR4:  w_npc = w_pc_add_4 + w_off;
      NPC_JR:   w_npc = bus.rs_val;
      NPC_JAL:  w_npc = w_j_tgt;
`ifdef NPC_RAS_EN
      NPC_RET:  w_npc = w_ras_empty ? bus.rs_val : w_ras_top;
`else
      NPC_RET:  w_npc = bus.rs_val;
`endif
      default:  w_npc = w_pc_add_4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)           r_pc <= RESET_PC;
    else if (bus.exc_req) r_pc <= EXC_VEC;
    else if (!bus.stall)  r_pc <= w_npc;
  end

  assign bus.pc       = r_pc;
  assign bus.pc_add_4 = w_pc_add_4;
  assign bus.npc      = w_npc;

endmodule

// File: tb/tb_npc_pc_unit.sv
// Directed bench for npc_pc_unit; the RAS section follows whether NPC_RAS_EN is defined.
module tb_npc_pc_unit;
  import npc_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  npc_pc_unit_if #(.WIDTH(32)) bus ();

  npc_pc_unit #(
    .WIDTH     (32),
    .RESET_PC  (32'h0000_3000),
    .EXC_VEC   (32'h0000_4180),
    .RAS_DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [15:0] i16, input logic [25:0] i26,
                       input logic [31:0] rs, input logic st, input logic ex);
    bus.npc_op  = op;
    bus.imm_16  = i16;
    bus.imm_26  = i26;
    bus.rs_val  = rs;
    bus.stall   = st;
    bus.exc_req = ex;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [15:0] i16, input logic [25:0] i26,
                       input logic [31:0] rs);
    drive(op, i16, i26, rs, 1'b0, 1'b0);
    tick();
  endtask

  task automatic do_reset();
    drive(NPC_SEQ, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // reset and sequential stepping
    drive(NPC_SEQ, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    check("reset_pc", bus.pc, 32'h0000_3000);
    check("reset_ras_empty", 32'(bus.ras_empty), 32'h1);
    check("reset_pc_add_4", bus.pc_add_4, 32'h0000_3004);
    check("reset_npc_seq", bus.npc, 32'h0000_3004);
    rst_n = 1'b1;
    repeat (3) do_op(NPC_SEQ, 16'h0, 26'h0, 32'h0);
    check("seq_x3", bus.pc, 32'h0000_300C);

    // branches
    do_op(NPC_SEQ, 16'h0, 26'h0, 32'h0);
    check("seq_to_3010", bus.pc, 32'h0000_3010);
    drive(NPC_BR4, 16'hFFFF, 26'h0, 32'h0, 1'b0, 1'b0);
    #1;
    check("br4_npc", bus.npc, 32'h0000_3010);
    tick();
    check("br4_pc", bus.pc, 32'h0000_3010);
    do_op(NPC_BRPC, 16'h0004, 26'h0, 32'h0);
    check("brpc_pc", bus.pc, 32'h0000_3020);

    // jumps
    do_reset();
    do_op(NPC_SEQ, 16'h0, 26'h0, 32'h0);
    check("seq_to_3004", bus.pc, 32'h0000_3004);
    drive(NPC_J, 16'h0, 26'h000_0C40, 32'h0, 1'b0, 1'b0);
    #1;
    check("j_npc", bus.npc, 32'h0000_3100);
    tick();
    check("j_pc", bus.pc, 32'h0000_3100);
    do_op(NPC_JR, 16'h0, 26'h0, 32'h0000_3400);
    check("jr_pc", bus.pc, 32'h0000_3400);

    // stall and exception
    drive(NPC_J, 16'h0, 26'h000_0C40, 32'h0, 1'b1, 1'b0);
    tick();
    check("stall_hold", bus.pc, 32'h0000_3400);
    check("stall_npc", bus.npc, 32'h0000_3100);
    drive(NPC_J, 16'h0, 26'h000_0C40, 32'h0, 1'b1, 1'b1);
    tick();
    check("exc_over_stall", bus.pc, 32'h0000_4180);
    do_op(NPC_RSV, 16'h1234, 26'h1, 32'h5);
    check("reserved_op", bus.pc, 32'h0000_4184);

    // modulo wrap and upper-bit preservation on J
    do_op(NPC_JR, 16'h0, 26'h0, 32'hFFFF_FFFC);
    do_op(NPC_SEQ, 16'h0, 26'h0, 32'h0);
    check("seq_wrap", bus.pc, 32'h0000_0000);
    do_op(NPC_BRPC, 16'hFFFF, 26'h0, 32'h0);
    check("brpc_wrap", bus.pc, 32'hFFFF_FFFC);
    do_op(NPC_J, 16'h0, 26'h000_0040, 32'h0);
    check("j_keep_hi", bus.pc, 32'hF000_0100);

    // reset beats exception
    drive(NPC_SEQ, 16'h0, 26'h0, 32'h0, 1'b0, 1'b1);
    rst_n = 1'b0;
    tick();
    check("rst_over_exc", bus.pc, 32'h0000_3000);
    rst_n = 1'b1;

`ifdef NPC_RAS_EN
    do_op(NPC_JAL, 16'h0, 26'h000_0C80, 32'h0);
    exp_q.push_back(32'h0000_3004);
    check("jal1_pc", bus.pc, 32'h0000_3200);
    check("jal1_ras_nonempty", 32'(bus.ras_empty), 32'h0);
    do_op(NPC_JAL, 16'h0, 26'h000_0D00, 32'h0);
    exp_q.push_back(32'h0000_3204);
    check("jal2_pc", bus.pc, 32'h0000_3400);
    drive(NPC_RET, 16'h0, 26'h0, 32'h0000_3500, 1'b1, 1'b0);
    tick();
    check("ret_stalled_hold", bus.pc, 32'h0000_3400);
    do_op(NPC_RET, 16'h0, 26'h0, 32'h0000_3500);
    check("ret1_pc", bus.pc, exp_q.pop_back());
    do_op(NPC_RET, 16'h0, 26'h0, 32'h0000_3500);
    check("ret2_pc", bus.pc, exp_q.pop_back());
    do_op(NPC_RET, 16'h0, 26'h0, 32'h0000_3500);
    check("ret_empty_pc", bus.pc, 32'h0000_3500);
    check("ret_empty_flag", 32'(bus.ras_empty), 32'h1);

    // overflow: five pushes into four entries keep the newest four
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      logic [31:0] tgt;
      tgt = 32'h0000_3000 + 32'h100 * k;
      exp_q.push_back(32'h0000_3000 + 32'h100 * (k - 1) + 32'h4);
      do_op(NPC_JAL, 16'h0, tgt[27:2], 32'h0);
      check("jal_fill_pc", bus.pc, tgt);
    end
    void'(exp_q.pop_front());
    for (int k = 0; k < 4; k++) begin
      do_op(NPC_RET, 16'h0, 26'h0, 32'hDEAD_0000);
      check("ret_lifo_pc", bus.pc, exp_q.pop_back());
    end
    check("ras_drained", 32'(bus.ras_empty), 32'h1);
`else
    do_op(NPC_JAL, 16'h0, 26'h000_0040, 32'h0);
    check("jal_as_j_pc", bus.pc, 32'h0000_0100);
    check("jal_no_push", 32'(bus.ras_empty), 32'h1);
    do_op(NPC_RET, 16'h0, 26'h0, 32'h0000_3008);
    check("ret_as_jr_pc", bus.pc, 32'h0000_3008);
    exp_q.push_back(32'h0000_300C);
    do_op(NPC_SEQ, 16'h0, 26'h0, 32'h0);
    check("seq_after_ret", bus.pc, exp_q.pop_front());
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
